// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch/issue engine: owns the PC, fetches over req/ack, issues fields to the CU.
// Optional FETCH_TIMEOUT_EN adds a fetch-wait counter and a sticky FAULT state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic        PCSrc,
  input  logic [31:0] imm_ext,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;
  logic        fault_q;
  logic [31:0] pc_seq_d;
  logic [31:0] pc_br_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
`endif

  assign pc_seq_d = pc_q + 32'd4;
  assign pc_br_d  = pc_seq_d + (imm_ext << 2);

  // req_q is low for one cycle after reset, so an ack there is ignored
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ISSUE;
`ifdef FETCH_TIMEOUT_EN
            cnt_q   <= '0;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            req_q   <= 1'b0;
            fault_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= FAULT;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        ISSUE: begin
          if (!PCWre) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            pc_q    <= PCSrc ? pc_br_d : pc_seq_d;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: begin
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign opcode      = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign imm16       = instr_q[15:0];
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule
